// File: rtl/tlc_phase_scheduler.sv
// Two-road intersection phase scheduler with pedestrian walk.
// Sequences green/yellow/all-red per road in TICK units, arbitrated by TA/TB demand and a latched PED_REQ.
module tlc_phase_scheduler #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned T_MIN_GREEN = 5,
    parameter int unsigned T_MAX_GREEN = 20,
    parameter int unsigned T_YELLOW    = 3,
    parameter int unsigned T_ALLRED    = 1,
    parameter int unsigned T_WALK      = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TICK,
    input  logic       TA,
    input  logic       TB,
    input  logic       PED_REQ,
    output logic [1:0] LA,
    output logic [1:0] LB,
    output logic       WALK,
    output logic       PED_PENDING,
    output logic [2:0] PHASE
);

    typedef enum logic [2:0] {
        A_GREEN   = 3'd0,
        A_YELLOW  = 3'd1,
        ALLRED_AB = 3'd2,
        B_GREEN   = 3'd3,
        B_YELLOW  = 3'd4,
        ALLRED_BA = 3'd5,
        PED_WALK  = 3'd6
    } state_e;

    localparam logic [1:0] RED = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] GRN = 2'b11;

    // Timer value on the final tick of each timed phase
    localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(T_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(T_WALK - 1);

    // Held as raw bits so the unused code 7 stays representable and recoverable
    logic [2:0]       state_q;
    state_e           state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             ped_q, ped_d;
    logic             side_a_q, side_a_d;
    logic             min_ok, max_hit;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= A_GREEN;
            timer_q  <= '0;
            ped_q    <= 1'b0;
            side_a_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            ped_q    <= ped_d;
            side_a_q <= side_a_d;
        end
    end

    always_comb begin
        state_d  = state_e'(state_q);
        side_a_d = side_a_q;
        min_ok   = (timer_q >= MIN_LAST);
        max_hit  = (timer_q >= MAX_LAST);
        case (state_q)
            A_GREEN:
                if (TICK && min_ok && (TB || ped_q) && (!TA || max_hit))
                    state_d = A_YELLOW;
            A_YELLOW:
                if (TICK && timer_q == YEL_LAST) state_d = ALLRED_AB;
            ALLRED_AB:
                if (TICK && timer_q == AR_LAST) begin
                    if (ped_q) begin
                        state_d  = PED_WALK;
                        side_a_d = 1'b0;
                    end else begin
                        state_d = B_GREEN;
                    end
                end
            B_GREEN:
                if (TICK && min_ok && (TA || ped_q) && (!TB || max_hit))
                    state_d = B_YELLOW;
            B_YELLOW:
                if (TICK && timer_q == YEL_LAST) state_d = ALLRED_BA;
            ALLRED_BA:
                if (TICK && timer_q == AR_LAST) begin
                    if (ped_q) begin
                        state_d  = PED_WALK;
                        side_a_d = 1'b1;
                    end else begin
                        state_d = A_GREEN;
                    end
                end
            PED_WALK:
                if (TICK && timer_q == WALK_LAST)
                    state_d = side_a_q ? A_GREEN : B_GREEN;
            default: state_d = ALLRED_BA;
        endcase

        if (state_d != state_q)
            timer_d = '0;
        else if (TICK && timer_q < MAX_LAST)
            timer_d = timer_q + CNT_W'(1);
        else
            timer_d = timer_q;

        // A new request on the walk-entry edge survives to the next all-red
        ped_d = PED_REQ | (ped_q & ~((state_d == PED_WALK) && (state_q != PED_WALK)));
    end

    // Moore light decode of the state register only
    always_comb begin
        LA   = RED;
        LB   = RED;
        WALK = 1'b0;
        case (state_q)
            A_GREEN:  LA = GRN;
            A_YELLOW: LA = YEL;
            B_GREEN:  LB = GRN;
            B_YELLOW: LB = YEL;
            PED_WALK: WALK = 1'b1;
            default:  ;
        endcase
    end

    assign PED_PENDING = ped_q;
    assign PHASE       = state_q;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Self-checking bench for tlc_phase_scheduler: timeline scenarios, pedestrian vector table,
// TICK freeze, asynchronous reset mid-yellow and recovery from the illegal phase code.
module tb_tlc_phase_scheduler;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       TICK = 1'b0, TA = 1'b0, TB = 1'b0, PED_REQ = 1'b0;
    logic [1:0] LA, LB;
    logic       WALK, PED_PENDING;
    logic [2:0] PHASE;

    tlc_phase_scheduler dut (
        .CLK(CLK), .RST(RST), .TICK(TICK), .TA(TA), .TB(TB), .PED_REQ(PED_REQ),
        .LA(LA), .LB(LB), .WALK(WALK), .PED_PENDING(PED_PENDING), .PHASE(PHASE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0] la;
        logic [1:0] lb;
        logic       walk;
        logic       ped;
        logic [2:0] phase;
    } obs_t;

    typedef struct packed {
        logic       ped_req;
        logic [2:0] ph;
        logic       pd;
    } vec_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    obs_t sb_q[$];

    function automatic obs_t exp_obs(input logic [2:0] ph, input logic pd);
        obs_t o;
        o.la    = (ph == 3'd0) ? 2'b11 : (ph == 3'd1) ? 2'b01 : 2'b00;
        o.lb    = (ph == 3'd3) ? 2'b11 : (ph == 3'd4) ? 2'b01 : 2'b00;
        o.walk  = (ph == 3'd6);
        o.ped   = pd;
        o.phase = ph;
        return o;
    endfunction

    // Expected phase after k ticks for TA=0, TB=1 from reset
    function automatic logic [2:0] tl_b_only(input int k);
        if (k < 5) return 3'd0;
        if (k < 8) return 3'd1;
        if (k < 9) return 3'd2;
        return 3'd3;
    endfunction

    // Expected phase after k ticks for TA=TB=1: 48-tick max-green cycle
    function automatic logic [2:0] tl_both(input int k);
        int m;
        m = k % 48;
        if (m < 20) return 3'd0;
        if (m < 23) return 3'd1;
        if (m < 24) return 3'd2;
        if (m < 44) return 3'd3;
        if (m < 47) return 3'd4;
        return 3'd5;
    endfunction

    task automatic compare(input string nm, input int idx, input obs_t exp);
        obs_t act;
        act = {LA, LB, WALK, PED_PENDING, PHASE};
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got la=%b lb=%b walk=%b ped=%b phase=%0d, want la=%b lb=%b walk=%b ped=%b phase=%0d",
                     nm, idx, act.la, act.lb, act.walk, act.ped, act.phase,
                     exp.la, exp.lb, exp.walk, exp.ped, exp.phase);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, check after the edge
    task automatic step(input logic tk, input logic ta, input logic tb, input logic pr,
                        input logic [2:0] ph, input logic pd, input string nm, input int idx);
        obs_t exp;
        @(negedge CLK);
        TICK = tk; TA = ta; TB = tb; PED_REQ = pr;
        sb_q.push_back(exp_obs(ph, pd));
        @(posedge CLK);
        #1;
        exp = sb_q.pop_front();
        compare(nm, idx, exp);
    endtask

    task automatic reset_dut(input logic ta, input logic tb);
        @(negedge CLK);
        RST = 1'b0; TICK = 1'b0; TA = ta; TB = tb; PED_REQ = 1'b0;
        repeat (2) @(negedge CLK);
        compare("reset_state", 0, exp_obs(3'd0, 1'b0));
        RST = 1'b1;
    endtask

    task automatic wait_phase(input logic [2:0] ph, input int budget, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            if (PHASE == ph) hit = 1'b1;
            else begin
                @(posedge CLK);
                #1;
            end
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: phase %0d not reached within %0d cycles, got %0d", nm, ph, budget, PHASE);
        end
    endtask

    vec_t tbl[27];

    initial begin
        // Pedestrian sequence with TA=TB=0: {PED_REQ before the edge, phase after, PED_PENDING after}
        tbl = '{
            '{1'b0, 3'd0, 1'b0}, '{1'b1, 3'd0, 1'b1}, '{1'b0, 3'd0, 1'b1}, '{1'b0, 3'd0, 1'b1},
            '{1'b0, 3'd1, 1'b1}, '{1'b0, 3'd1, 1'b1}, '{1'b0, 3'd1, 1'b1}, '{1'b0, 3'd2, 1'b1},
            '{1'b1, 3'd6, 1'b1}, '{1'b0, 3'd6, 1'b1}, '{1'b0, 3'd6, 1'b1}, '{1'b0, 3'd6, 1'b1},
            '{1'b0, 3'd3, 1'b1}, '{1'b0, 3'd3, 1'b1}, '{1'b0, 3'd3, 1'b1}, '{1'b0, 3'd3, 1'b1},
            '{1'b0, 3'd3, 1'b1}, '{1'b0, 3'd4, 1'b1}, '{1'b0, 3'd4, 1'b1}, '{1'b0, 3'd4, 1'b1},
            '{1'b0, 3'd5, 1'b1}, '{1'b0, 3'd6, 1'b0}, '{1'b1, 3'd6, 1'b1}, '{1'b0, 3'd6, 1'b1},
            '{1'b0, 3'd6, 1'b1}, '{1'b0, 3'd0, 1'b1}, '{1'b0, 3'd0, 1'b1}
        };

        // A has traffic, B none: A keeps green forever
        reset_dut(1'b1, 1'b0);
        for (int k = 1; k <= 50; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, "a_hold", k);

        // B demand only: minimum green then hand over to B
        reset_dut(1'b0, 1'b1);
        for (int k = 1; k <= 20; k++) step(1'b1, 1'b0, 1'b1, 1'b0, tl_b_only(k), 1'b0, "b_demand", k);

        // Both roads busy: max-green alternation
        reset_dut(1'b1, 1'b1);
        for (int k = 1; k <= 100; k++) step(1'b1, 1'b1, 1'b1, 1'b0, tl_both(k), 1'b0, "both_max", k);

        // Pedestrian table
        reset_dut(1'b0, 1'b0);
        for (int k = 0; k < 27; k++)
            step(1'b1, 1'b0, 1'b0, tbl[k].ped_req, tbl[k].ph, tbl[k].pd, "ped_tbl", k + 1);

        // TICK held low mid-yellow freezes state and timer
        reset_dut(1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) step(1'b1, 1'b0, 1'b1, 1'b0, tl_b_only(k), 1'b0, "freeze_pre", k);
        for (int k = 1; k <= 100; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, "freeze_hold", k);
        step(1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, "freeze_resume", 1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, "freeze_resume", 2);
        step(1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, "freeze_resume", 3);

        // Asynchronous reset in B_YELLOW with a pending pedestrian
        reset_dut(1'b0, 1'b1);
        TICK = 1'b1;
        wait_phase(3'd3, 20, "reach_b_green");
        @(negedge CLK);
        PED_REQ = 1'b1; TB = 1'b0;
        @(negedge CLK);
        PED_REQ = 1'b0;
        wait_phase(3'd4, 40, "reach_b_yellow");
        #2;
        compare("pre_async_rst", 0, exp_obs(3'd4, 1'b1));
        RST = 1'b0;
        #1;
        compare("async_rst", 0, exp_obs(3'd0, 1'b0));

        // Illegal phase code: all red, then ALLRED_BA, then A_GREEN
        reset_dut(1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, "pre_illegal", k);
        @(negedge CLK);
        force dut.state_q = 3'd7;
        #1;
        compare("illegal_red", 0, exp_obs(3'd7, 1'b0));
        @(posedge CLK);
        @(negedge CLK);
        release dut.state_q;
        #1;
        wait_phase(3'd5, 4, "illegal_to_allred");
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, "illegal_recover", 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, "illegal_recover", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
